// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Burst command channel between the port arbiter and the SDRAM core.
//   master : arbiter side (drives cmd_valid/cmd_write/cmd_port/cmd_addr/cmd_len)
//   slave  : SDRAM core side (drives cmd_ready/cmd_done)
//   cmd_done is a single-cycle pulse when an accepted burst has completed.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_port;
  logic [ADDR_W-1:0] cmd_addr;
  logic [9:0]        cmd_len;
  logic              cmd_done;

  modport master (
    output cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Arbitrates four FIFO ports (0=wr1, 1=wr2, 2=rd1, 3=rd2) onto one SDRAM
//   burst command channel. Each port owns a frame address pointer that walks
//   from port_base to port_max in BURST_LEN steps and wraps, pulsing
//   port_finish on the wrap.
//
//   Ports:
//     clk, rst_n   clock / async active-low reset (release synchronised inside)
//     init_done    SDRAM initialised; dropping it aborts to IDLE
//     fifo_use     per-port FIFO fill level {rd2,rd1,wr2,wr1}, 9 bits each
//     port_base    per-port frame start address
//     port_max     per-port frame end address (exclusive)
//     port_load    per-port pulse: reload pointer from port_base
//     port_finish  per-port pulse: frame wrapped
//     cmd          burst command channel (sdram_port_arbiter_if.master)
//
//   Build option: define ARB_WR_PRIORITY_EN to let any eligible write port
//   beat every read port (round-robin kept inside each pair). Undefined gives
//   plain 4-way round-robin.

// Per-port pointer / eligibility lane.
module sdram_port_ptr #(
  parameter int ADDR_W    = 21,
  parameter int BURST_LEN = 256,
  parameter int RD_THRESH = 256,
  parameter bit IS_WRITE  = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [8:0]        use_lvl,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic              reload,
  input  logic              adv,
  output logic              elig,
  output logic [ADDR_W-1:0] ptr,
  output logic              finish
);
  // One extra bit so a pointer near the top of the address space cannot
  // wrap around before the frame-end compare.
  logic [ADDR_W:0] nxt;
  assign nxt = {1'b0, ptr} + (ADDR_W+1)'(BURST_LEN);

  always_comb begin
    if (IS_WRITE) elig = ({1'b0, use_lvl} >= 10'(BURST_LEN));
    else          elig = ({1'b0, use_lvl} <  10'(RD_THRESH));
  end

  // reload beats adv: a load coincident with completion neither advances
  // nor reports a wrap.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr    <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (reload) begin
        ptr <= base;
      end else if (adv) begin
        if (nxt >= {1'b0, max_addr}) begin
          ptr    <= base;
          finish <= 1'b1;
        end else begin
          ptr <= nxt[ADDR_W-1:0];
        end
      end
    end
  end
endmodule

module sdram_port_arbiter #(
  parameter int ADDR_W    = 21,
  parameter int BURST_LEN = 256,
  parameter int RD_THRESH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic [3:0][8:0]        fifo_use,
  input  logic [3:0][ADDR_W-1:0] port_base,
  input  logic [3:0][ADDR_W-1:0] port_max,
  input  logic [3:0]             port_load,
  output logic [3:0]             port_finish,
  sdram_port_arbiter_if.master   cmd
);
  typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT} state_t;

  // Assertion is immediate, release is delayed by two clk edges.
  logic [1:0] rst_sync;
  logic       arst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arst_n = rst_sync[1];

  state_t                   state, state_d;
  logic                     latch;
  logic [3:0]               elig, elig_m;
  logic [1:0]               last_grant, grant, idx;
  logic                     grant_vld;
  logic                     done_hit;
  logic [3:0][ADDR_W-1:0]   ptr;
  logic [1:0]               port_q;
  logic                     write_q;
  logic [ADDR_W-1:0]        addr_q;

  // Completion only counts while waiting on a live burst.
  assign done_hit = (state == WAIT) && init_done && cmd.cmd_done;

  for (genvar i = 0; i < 4; i++) begin : g_port
    sdram_port_ptr #(
      .ADDR_W   (ADDR_W),
      .BURST_LEN(BURST_LEN),
      .RD_THRESH(RD_THRESH),
      .IS_WRITE (i < 2)
    ) u_ptr (
      .clk     (clk),
      .arst_n  (arst_n),
      .use_lvl (fifo_use[i]),
      .base    (port_base[i]),
      .max_addr(port_max[i]),
      .reload  (((state == IDLE) && init_done) ||
                ((state != IDLE) && port_load[i])),
      .adv     (done_hit && (port_q == 2'(i))),
      .elig    (elig[i]),
      .ptr     (ptr[i]),
      .finish  (port_finish[i])
    );
  end

  // Round-robin: walk offsets 4..1 from last_grant so the nearest eligible
  // port after last_grant is the final (winning) assignment.
  always_comb begin
    elig_m = elig;
`ifdef ARB_WR_PRIORITY_EN
    if (|elig[1:0]) elig_m[3:2] = 2'b00;
`endif
    grant = last_grant;
    idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_grant + 2'(k + 1);
      if (elig_m[idx]) grant = idx;
    end
  end
  assign grant_vld = |elig_m;

  always_comb begin
    state_d = state;
    latch   = 1'b0;
    case (state)
      IDLE: if (init_done) state_d = ARB;
      ARB: begin
        if (grant_vld) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ:  if (cmd.cmd_ready) state_d = WAIT;
      WAIT: if (cmd.cmd_done)  state_d = ARB;
      default: state_d = IDLE;
    endcase
    if (!init_done) begin
      state_d = IDLE;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      port_q     <= 2'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      state <= state_d;
      // Command fields are captured once; later port_load does not touch them.
      if (latch) begin
        port_q  <= grant;
        write_q <= ~grant[1];
        addr_q  <= ptr[grant];
      end
      if (done_hit) last_grant <= port_q;
    end
  end

  assign cmd.cmd_valid = (state == REQ);
  assign cmd.cmd_write = write_q;
  assign cmd.cmd_port  = port_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_len   = 10'(BURST_LEN);
endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
  localparam int AW = 21;
  localparam int BL = 256;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                init_done;
  logic [3:0][8:0]     fifo_use;
  logic [3:0][AW-1:0]  port_base;
  logic [3:0][AW-1:0]  port_max;
  logic [3:0]          port_load;
  logic [3:0]          port_finish;

  sdram_port_arbiter_if #(.ADDR_W(AW)) cmd_if();

  sdram_port_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .RD_THRESH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .fifo_use   (fifo_use),
    .port_base  (port_base),
    .port_max   (port_max),
    .port_load  (port_load),
    .port_finish(port_finish),
    .cmd        (cmd_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame pointers, round-robin history, current fill levels.
  int m_ptr[4];
  int m_base[4];
  int m_max[4];
  int m_last;
  int cur_use[4];

  int fin3 = 0;
  always @(negedge clk) if (port_finish[3]) fin3++;

  typedef struct {
    int u0, u1, u2, u3;
    int exp_def;
    int exp_pri;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_use(input int a, input int b, input int c, input int d);
    cur_use[0] = a; cur_use[1] = b; cur_use[2] = c; cur_use[3] = d;
    for (int i = 0; i < 4; i++) fifo_use[i] = 9'(cur_use[i]);
  endtask

  // Spec-level grant rule: first eligible port after the last one served.
  function automatic int model_grant();
    bit e[4];
    for (int i = 0; i < 4; i++)
      e[i] = (i < 2) ? (cur_use[i] >= BL) : (cur_use[i] < 256);
`ifdef ARB_WR_PRIORITY_EN
    if (e[0] | e[1]) begin e[2] = 1'b0; e[3] = 1'b0; end
`endif
    for (int k = 1; k <= 4; k++)
      if (e[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic model_reinit();
    for (int i = 0; i < 4; i++) m_ptr[i] = m_base[i];
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!cmd_if.cmd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_if.cmd_valid;
    check("valid_wait", ok, 1);
  endtask

  // One full burst: check the command, hold it `hold` cycles, accept,
  // complete, then check the wrap pulse against the model.
  task automatic burst(input int p, input int hold, input bit load_on_done,
                       input bit load_in_req);
    bit ok;
    logic [AW-1:0] a0;
    logic [3:0] fin_exp;
    fin_exp = '0;
    wait_valid(ok);
    if (!ok) return;
    check("finish_clear", port_finish, 0);
    check("port", cmd_if.cmd_port, p);
    check("write", cmd_if.cmd_write, (p < 2));
    check("addr", cmd_if.cmd_addr, m_ptr[p]);
    check("len", cmd_if.cmd_len, BL);
    a0 = cmd_if.cmd_addr;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("valid_hold", cmd_if.cmd_valid, 1);
      check("addr_hold", cmd_if.cmd_addr, a0);
    end
    if (load_in_req) begin
      port_load[p] = 1'b1;
      @(negedge clk);
      port_load = '0;
      m_ptr[p] = m_base[p];
      check("addr_after_load", cmd_if.cmd_addr, a0);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check("valid_drop", cmd_if.cmd_valid, 0);
    cmd_if.cmd_done = 1'b1;
    if (load_on_done) port_load[p] = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    port_load = '0;
    if (load_on_done)                  m_ptr[p] = m_base[p];
    else if (m_ptr[p] + BL >= m_max[p]) begin m_ptr[p] = m_base[p]; fin_exp[p] = 1'b1; end
    else                               m_ptr[p] = m_ptr[p] + BL;
    m_last = p;
    check("finish", port_finish, fin_exp);
  endtask

  task automatic mburst(input int hold);
    int g;
    g = model_grant();
    if (g < 0) begin
      repeat (3) @(negedge clk);
      check("no_grant", cmd_if.cmd_valid, 0);
    end else begin
      burst(g, hold, 1'b0, 1'b0);
    end
  endtask

  // Pointer reload while nothing is eligible, so no grant races the load.
  task automatic reload_quiet(input logic [3:0] mask);
    set_use(0, 0, 300, 300);
    repeat (2) @(negedge clk);
    port_load = mask;
    @(negedge clk);
    port_load = '0;
    for (int i = 0; i < 4; i++) if (mask[i]) m_ptr[i] = m_base[i];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int picks[6] = '{0, 100, 255, 256, 300, 511};
    int f0;
    bit ok;

    m_base = '{0, 262144, 524288, 921600};
    m_max  = '{262144, 262144 + 1000, 786432, 1228800};
    for (int i = 0; i < 4; i++) begin
      port_base[i] = AW'(m_base[i]);
      port_max[i]  = AW'(m_max[i]);
    end
    rst_n = 1'b0; init_done = 1'b1; port_load = '0;
    cmd_if.cmd_ready = 1'b0; cmd_if.cmd_done = 1'b0;
    set_use(256, 0, 0, 0);
    repeat (3) @(negedge clk);

    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_port", cmd_if.cmd_port, 0);
    check("rst_write", cmd_if.cmd_write, 0);
    check("rst_addr", cmd_if.cmd_addr, 0);
    check("rst_finish", port_finish, 0);

    // Release: two sync edges, one into ARB, then cmd_valid.
    model_reinit();
    m_last = 3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_release_quiet", cmd_if.cmd_valid, 0);
    @(negedge clk);
    check("rst_release_valid", cmd_if.cmd_valid, 1);

    tbl.push_back('{256, 0,   0,   0,   0, 0});
    tbl.push_back('{0,   0,   0,   300, 2, 2});
    tbl.push_back('{300, 300, 0,   0,   3, 0});
    tbl.push_back('{300, 300, 0,   0,   0, 1});
    tbl.push_back('{300, 300, 0,   0,   1, 0});
    tbl.push_back('{100, 100, 100, 500, 2, 2});
    tbl.push_back('{511, 0,   511, 100, 3, 0});
    tbl.push_back('{255, 256, 256, 255, 1, 1});
    tbl.push_back('{0,   0,   256, 255, 3, 3});
    tbl.push_back('{256, 0,   0,   0,   0, 0});
    tbl.push_back('{256, 0,   300, 300, 0, 0});
    foreach (tbl[i]) begin
      set_use(tbl[i].u0, tbl[i].u1, tbl[i].u2, tbl[i].u3);
`ifdef ARB_WR_PRIORITY_EN
      burst(tbl[i].exp_pri, i % 3, 1'b0, 1'b0);
`else
      burst(tbl[i].exp_def, i % 3, 1'b0, 1'b0);
`endif
    end

    // Nothing eligible: arbiter must sit in ARB.
    set_use(0, 0, 300, 300);
    repeat (10) @(negedge clk);
    check("idle_no_elig", cmd_if.cmd_valid, 0);

    // wr1 vs rd1 alternation (or write priority).
    set_use(300, 0, 0, 300);
    repeat (4) mburst(0);

    // Load coincident with completion at pointer base+1024.
    reload_quiet(4'b0001);
    set_use(256, 0, 300, 300);
    repeat (4) burst(0, 0, 1'b0, 1'b0);
    check("ptr_before_load", m_ptr[0] - m_base[0] == 1024, 1);
    burst(0, 0, 1'b1, 1'b0);
    burst(0, 0, 1'b0, 1'b0);
    // Load during REQ leaves the latched address alone.
    burst(0, 1, 1'b0, 1'b1);
    burst(0, 0, 1'b0, 1'b0);

    // init_done falling in REQ abandons the burst; re-init reloads pointers.
    set_use(256, 256, 0, 0);
    wait_valid(ok);
    init_done = 1'b0;
    @(negedge clk);
    check("init_drop_valid", cmd_if.cmd_valid, 0);
    @(negedge clk);
    init_done = 1'b1;
    model_reinit();
    mburst(0);

    // Randomized fill levels against the model.
    for (int r = 0; r < 40; r++) begin
      set_use(picks[$urandom_range(0, 5)], picks[$urandom_range(0, 5)],
              picks[$urandom_range(0, 5)], picks[$urandom_range(0, 5)]);
      mburst($urandom_range(0, 2));
    end

    // Full frame on port 3: exactly one wrap on the 1200th completion.
    reload_quiet(4'b1000);
    set_use(0, 0, 300, 0);
    f0 = fin3;
    for (int b = 0; b < 1200; b++) burst(3, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("p3_finish_count", fin3 - f0, 1);
    burst(3, 0, 1'b0, 1'b0);

    // Reset while a command is pending.
    set_use(256, 256, 0, 0);
    wait_valid(ok);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", cmd_if.cmd_valid, 0);
    check("rst_mid_port", cmd_if.cmd_port, 0);
    check("rst_mid_addr", cmd_if.cmd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reinit();
    m_last = 3;
    burst(0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
